// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with registered read ports, stall hold and valid flag.
// Entry 0 reads as zero. Define REGFILE_BYPASS_EN for write-first forwarding on same-cycle hazards.
module regfile_2r1w #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr_a,
  input  logic [ADDR_BITS-1:0] raddr_b,
  output logic [WIDTH-1:0]     rdata_a,
  output logic [WIDTH-1:0]     rdata_b,
  output logic                 rvalid
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
  logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
  logic             rvalid_q;
  logic             wr_en;

  assign wr_en = we && (waddr != '0);

  // Address 0 is decoded explicitly so it can never be forwarded or read as nonzero.
  always_comb begin
    rdata_a_d = '0;
    rdata_b_d = '0;
    if (raddr_a != '0) begin
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (waddr == raddr_a)) rdata_a_d = wdata;
      else                              rdata_a_d = mem_q[raddr_a];
`else
      rdata_a_d = mem_q[raddr_a];
`endif
    end
    if (raddr_b != '0) begin
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (waddr == raddr_b)) rdata_b_d = wdata;
      else                              rdata_b_d = mem_q[raddr_b];
`else
      rdata_b_d = mem_q[raddr_b];
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      if (wr_en) mem_q[waddr] <= wdata;
      if (re) begin
        rdata_a_q <= rdata_a_d;
        rdata_b_q <= rdata_b_d;
        rvalid_q  <= 1'b1;
      end
    end
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;
  assign rvalid  = rvalid_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: reference array model plus a read scoreboard queue.
// Builds for either setting of REGFILE_BYPASS_EN; the expected hazard result follows the macro.
module tb_regfile_2r1w;

  localparam int W  = 32;
  localparam int AB = 5;
  localparam int N  = 1 << AB;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          we = 1'b0;
  logic [AB-1:0] waddr = '0;
  logic [W-1:0]  wdata = '0;
  logic          re = 1'b0;
  logic [AB-1:0] raddr_a = '0;
  logic [AB-1:0] raddr_b = '0;
  logic [W-1:0]  rdata_a, rdata_b;
  logic          rvalid;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]   model [N];
  logic [2*W-1:0] sb [$];
  logic [W-1:0]   holdA = '0, holdB = '0;
  logic           holdV = 1'b0;

  regfile_2r1w #(.WIDTH(W), .ADDR_BITS(AB)) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .rvalid(rvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired: got timeout, want completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] expRead(input logic [AB-1:0] ra, input logic w,
                                           input logic [AB-1:0] wa, input logic [W-1:0] wd);
    logic [W-1:0] v;
    if (ra == '0) v = '0;
    else v = model[ra];
`ifdef REGFILE_BYPASS_EN
    if (ra != '0 && w && wa == ra) v = wd;
`endif
    return v;
  endfunction

  // One clock cycle: drive after the falling edge, score after the rising edge.
  task automatic applyStimulus(input string tag, input logic w, input logic [AB-1:0] wa,
                               input logic [W-1:0] wd, input logic r,
                               input logic [AB-1:0] ra, input logic [AB-1:0] rb);
    logic [2*W-1:0] e;
    @(negedge clk);
    we = w; waddr = wa; wdata = wd; re = r; raddr_a = ra; raddr_b = rb;
    if (r) sb.push_back({expRead(ra, w, wa, wd), expRead(rb, w, wa, wd)});
    @(posedge clk);
    #1;
    if (w && wa != '0) model[wa] = wd;
    if (r) begin
      if (sb.size() == 0) begin
        checkOutput({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        holdA = e[2*W-1:W];
        holdB = e[W-1:0];
        holdV = 1'b1;
      end
    end
    checkOutput({tag, "_a"}, rdata_a, holdA);
    checkOutput({tag, "_b"}, rdata_b, holdB);
    checkOutput({tag, "_v"}, {31'd0, rvalid}, {31'd0, holdV});
    @(negedge clk);
    we = 1'b0; re = 1'b0;
  endtask

  task automatic clearModel();
    for (int i = 0; i < N; i++) model[i] = '0;
    holdA = '0; holdB = '0; holdV = 1'b0;
    sb.delete();
  endtask

  initial begin
    clearModel();
    $display("[TB] start");
    #12;
    checkOutput("rst_a", rdata_a, '0);
    checkOutput("rst_v", {31'd0, rvalid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    applyStimulus("wr7", 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
    applyStimulus("rd7", 1'b0, 5'd0, '0, 1'b1, 5'd7, 5'd7);

    // Asynchronous reset between edges: outputs must clear with no clock edge.
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("arst_a", rdata_a, '0);
    checkOutput("arst_b", rdata_b, '0);
    checkOutput("arst_v", {31'd0, rvalid}, 32'd0);
    clearModel();
    @(negedge clk);
    reset = 1'b1;
    applyStimulus("arst_rd7", 1'b0, 5'd0, '0, 1'b1, 5'd7, 5'd0);

    applyStimulus("wr0", 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0);
    applyStimulus("rd0", 1'b0, 5'd0, '0, 1'b1, 5'd0, 5'd0);

    applyStimulus("wr3", 1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 5'd0);
    applyStimulus("wr31", 1'b1, 5'd31, 32'h22, 1'b0, 5'd0, 5'd0);
    applyStimulus("dual", 1'b0, 5'd0, '0, 1'b1, 5'd3, 5'd31);

    applyStimulus("stall_rd", 1'b0, 5'd0, '0, 1'b1, 5'd3, 5'd3);
    for (int i = 0; i < 3; i++) applyStimulus("stall_hold", 1'b1, 5'd3, 32'h99, 1'b0, 5'd3, 5'd3);
    applyStimulus("stall_rel", 1'b0, 5'd0, '0, 1'b1, 5'd3, 5'd0);

    applyStimulus("haz_wr", 1'b1, 5'd5, 32'hA, 1'b0, 5'd0, 5'd0);
    applyStimulus("haz", 1'b1, 5'd5, 32'hB, 1'b1, 5'd5, 5'd0);
    applyStimulus("haz_next", 1'b0, 5'd0, '0, 1'b1, 5'd5, 5'd5);
    applyStimulus("haz_zero", 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd5);

    for (int i = 1; i < N; i++) applyStimulus("wr_idx", 1'b1, AB'(i), W'(i), 1'b0, 5'd0, 5'd0);
    applyStimulus("pair_1_31", 1'b0, 5'd0, '0, 1'b1, 5'd1, 5'd31);
    applyStimulus("pair_30_2", 1'b0, 5'd0, '0, 1'b1, 5'd30, 5'd2);

    for (int i = 0; i < 60; i++)
      applyStimulus("rand", 1'($urandom_range(1)), AB'($urandom), $urandom,
                    1'($urandom_range(1)), AB'($urandom), AB'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Two-read, one-write general-purpose register file for the MIPS datapath, the read-side complement to the single load-enabled `register`. It holds 2^ADDR_BITS words of WIDTH bits, accepts one write per cycle from the writeback stage, and returns two operands per cycle to the decode stage through registered read ports with a one-cycle latency, a hold (stall) control and a valid flag. Entry 0 is hardwired to zero, as MIPS `$zero` requires.

## Interface
- WIDTH, 32, bits per register entry and per data port.
- ADDR_BITS, 5, address width; the array holds 2^ADDR_BITS entries.
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- we  input  1  write enable; 1 writes wdata to entry waddr at the rising edge.
- waddr  input  ADDR_BITS  write address.
- wdata  input  WIDTH  write data.
- re  input  1  read enable; 1 samples both read ports, 0 holds the outputs (stall).
- raddr_a  input  ADDR_BITS  read address, port A.
- raddr_b  input  ADDR_BITS  read address, port B.
- rdata_a  output  WIDTH  registered read data, port A.
- rdata_b  output  WIDTH  registered read data, port B.
- rvalid  output  1  1 when rdata_a/rdata_b hold data from a completed read.

## Operation
- Reset (reset=0, any time, asynchronous): every entry, rdata_a, rdata_b and rvalid become 0. State holds at 0 for as long as reset is 0. Operation resumes at the first rising edge after reset returns to 1.
- Write: at a rising edge with we=1 and waddr≠0, entry[waddr] takes wdata. With waddr=0 the write is discarded and entry 0 stays 0.
- Read: at a rising edge with re=1:
  - rdata_a takes entry[raddr_a].
  - rdata_b takes entry[raddr_b].
  - rvalid becomes 1.
- Stall: at a rising edge with re=0, rdata_a, rdata_b and rvalid keep their values. Writes proceed normally during a stall. Held outputs are not refreshed by writes.
- Address 0 on either read port always returns 0.
- Identical read addresses on A and B return identical data.
- Simultaneous read and write of the same nonzero address in one cycle: the result depends on the macro (see Configuration).
- Widths are exact. No sign extension, truncation or arithmetic takes place inside the block.

## Timing
- Write latency: 1 edge. A write at edge N is visible to a read sampled at edge N+1 or later.
- Read latency: 1 edge. Addresses are presented before edge N and the data is valid after edge N.
- rvalid rises 1 cycle after the first re=1 that follows reset. It then stays 1 until the next reset.
- No combinational path from any input to any output.
- Reset deassertion is synchronised externally. The block needs only the setup and hold of reset release relative to clk.

## Configuration
- REGFILE_BYPASS_EN defined: write-to-read forwarding.
  - At an edge where re=1, we=1 and waddr equals a nonzero raddr, that port's rdata takes wdata (write-first).
  - Forwarding applies independently to each port.
- REGFILE_BYPASS_EN undefined: read-before-write. In the same situation the port returns the old entry value, and the new value is visible from the next read onward.
- Address 0 is never forwarded in either build.

## Test plan
- Reset mid-operation:
  - Stimulus: write 0xDEADBEEF to entry 7, read entry 7 (rdata_a=0xDEADBEEF, rvalid=1), then pull reset low between edges.
  - Required response: rdata_a=0, rvalid=0 and entry 7 equals 0 immediately, with no clock edge.
- Zero register: write 0x12345678 to entry 0, then read raddr_a=raddr_b=0 -> rdata_a=rdata_b=0.
- Dual read: write 0x00000011 to entry 3 and 0x00000022 to entry 31, then read A=3, B=31 -> after one edge rdata_a=0x11, rdata_b=0x22.
- Stall hold:
  - Stimulus: read entry 3 (0x11); set re=0 and write 0x99 to entry 3 for 3 cycles; then re=1.
  - Required response: rdata_a stays 0x11 while re=0 and becomes 0x99 one edge after re returns to 1.
- Same-cycle hazard: entry 5 holds 0xA; in one cycle we=1, waddr=5, wdata=0xB, re=1, raddr_a=5.
  - With REGFILE_BYPASS_EN: rdata_a=0xB.
  - Without REGFILE_BYPASS_EN: rdata_a=0xA, and the next read returns 0xB.
- Wrap/boundary: with ADDR_BITS=5, write every entry 1..31 with its own index, then read pairs (1,31) and (30,2) -> rdata matches the index on both ports, with no aliasing.
